debug_unit: RTL and testbench

- Host-side controller for the MIPS pipeline; sits between the UART byte link and the pipeline top.
- Loads program words into instruction memory and controls execution through the halt line: continuous run or single step.
- After each run or step, snapshots registers, data memory and the four inter-stage latches, and streams them to the host byte by byte.

---
 rtl/debug_unit.sv | 206 ++++++++++++++++++++
 tb/tb_debug_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
// Host-side debug controller for the MIPS pipeline: loads instruction memory over the UART byte link,
// runs or single-steps the pipeline, then streams registers, data memory and stage latches back to the host.
module debug_unit #(
    parameter int N_REGS      = 32,
    parameter int N_MEM_WORDS = 32,
    parameter int NB_IF_ID    = 64,
    parameter int NB_ID_EX    = 139,
    parameter int NB_EX_MEM   = 76,
    parameter int NB_MEM_WB   = 71
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [7:0]           i_rx_data,
    input  logic                 i_rx_valid,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_start,
    input  logic                 i_tx_done,
    input  logic                 i_end,
    output logic                 o_halt,
    output logic                 o_write_instruction_mem,
    output logic [31:0]          o_instruction_mem_addr,
    output logic [31:0]          o_instruction_mem_data,
    output logic [4:0]           o_r_addr_registers,
    input  logic [31:0]          i_r_data_registers,
    output logic [4:0]           o_r_addr_data_mem,
    input  logic [31:0]          i_r_data_data_mem,
    input  logic [NB_IF_ID-1:0]  i_IF_ID,
    input  logic [NB_ID_EX-1:0]  i_ID_EX,
    input  logic [NB_EX_MEM-1:0] i_EX_MEM,
    input  logic [NB_MEM_WB-1:0] i_MEM_WB
);
    localparam int PB_IF_ID  = ((NB_IF_ID + 7) / 8) * 8;
    localparam int PB_ID_EX  = ((NB_ID_EX + 7) / 8) * 8;
    localparam int PB_EX_MEM = ((NB_EX_MEM + 7) / 8) * 8;
    localparam int PB_MEM_WB = ((NB_MEM_WB + 7) / 8) * 8;
    localparam int SNAP_W    = PB_IF_ID + PB_ID_EX + PB_EX_MEM + PB_MEM_WB;
    localparam logic [15:0] REG_BYTES  = 16'(4 * N_REGS);
    localparam logic [15:0] WORD_BYTES = 16'(4 * (N_REGS + N_MEM_WORDS));
    localparam logic [15:0] LAST_BYTE  = 16'(4 * (N_REGS + N_MEM_WORDS) + SNAP_W / 8 - 1);
    localparam logic [15:0] N_REGS_W   = 16'(N_REGS);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_COUNT, S_LOAD_BYTE, S_WRITE, S_RUN, S_STEP,
        S_DUMP_INIT, S_DUMP_FETCH, S_DUMP_LATCH, S_DUMP_WAIT
    } state_t;

    state_t             state_q;
    logic               halt_q, tx_start_q, we_q;
    logic [7:0]         tx_data_q, count_q, index_q;
    logic [31:0]        im_addr_q, im_data_q;
    logic [4:0]         raddr_reg_q, raddr_mem_q;
    logic [1:0]         lb_cnt_q;
    logic [23:0]        shreg_q;
    logic [15:0]        dump_cnt_q;
    logic [31:0]        word_q;
    logic [SNAP_W-1:0]  snap_q;

    logic [15:0]        next_byte_d;
    logic [4:0]         reg_addr_d, mem_addr_d;
    logic               fetch_reg_d;
    logic [7:0]         index_inc_d;
    logic [31:0]        load_word_d, rd_word_d;
    logic [SNAP_W-1:0]  snap_d;

    always_comb begin
        next_byte_d = dump_cnt_q + 16'd1;
        reg_addr_d  = 5'(next_byte_d >> 2);
        mem_addr_d  = 5'((next_byte_d >> 2) - N_REGS_W);
        fetch_reg_d = next_byte_d < REG_BYTES;
        index_inc_d = index_q + 8'd1;
        load_word_d = {shreg_q, i_rx_data};
        rd_word_d   = (dump_cnt_q < REG_BYTES) ? i_r_data_registers : i_r_data_data_mem;
        // Each latch is zero-extended to whole bytes so the stream can simply shift 8 bits at a time.
        snap_d      = {PB_IF_ID'(i_IF_ID), PB_ID_EX'(i_ID_EX), PB_EX_MEM'(i_EX_MEM), PB_MEM_WB'(i_MEM_WB)};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            halt_q      <= 1'b1;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'd0;
            we_q        <= 1'b0;
            im_addr_q   <= 32'd0;
            im_data_q   <= 32'd0;
            raddr_reg_q <= 5'd0;
            raddr_mem_q <= 5'd0;
            count_q     <= 8'd0;
            index_q     <= 8'd0;
            lb_cnt_q    <= 2'd0;
            dump_cnt_q  <= 16'd0;
        end else begin
            we_q       <= 1'b0;
            tx_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    halt_q <= 1'b1;
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            8'h4C: state_q <= S_LOAD_COUNT;
                            8'h43: begin state_q <= S_RUN;  halt_q <= 1'b0; end
                            8'h53: begin state_q <= S_STEP; halt_q <= 1'b0; end
                            default: state_q <= S_IDLE;
                        endcase
                    end
                end
                S_LOAD_COUNT: begin
                    if (i_rx_valid) begin
                        count_q  <= i_rx_data;
                        index_q  <= 8'd0;
                        lb_cnt_q <= 2'd0;
                        state_q  <= (i_rx_data == 8'd0) ? S_IDLE : S_LOAD_BYTE;
                    end
                end
                S_LOAD_BYTE: begin
                    if (i_rx_valid) begin
                        shreg_q  <= {shreg_q[15:0], i_rx_data};
                        lb_cnt_q <= lb_cnt_q + 2'd1;
                        if (lb_cnt_q == 2'd3) begin
                            we_q      <= 1'b1;
                            im_addr_q <= {22'd0, index_q, 2'b00};
                            im_data_q <= load_word_d;
                            state_q   <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    index_q  <= index_inc_d;
                    lb_cnt_q <= 2'd0;
                    if (index_inc_d == count_q) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_LOAD_BYTE;
                        // A byte arriving during the write cycle starts the next word.
                        if (i_rx_valid) begin
                            shreg_q  <= {shreg_q[15:0], i_rx_data};
                            lb_cnt_q <= 2'd1;
                        end
                    end
                end
                S_RUN: begin
                    if (i_end) begin
                        halt_q  <= 1'b1;
                        state_q <= S_DUMP_INIT;
                    end
                end
                S_STEP: begin
                    halt_q  <= 1'b1;
                    state_q <= S_DUMP_INIT;
                end
                S_DUMP_INIT: begin
                    snap_q      <= snap_d;
                    dump_cnt_q  <= 16'd0;
                    raddr_reg_q <= 5'd0;
                    raddr_mem_q <= 5'd0;
                    state_q     <= S_DUMP_FETCH;
                end
                S_DUMP_FETCH: state_q <= S_DUMP_LATCH;
                S_DUMP_LATCH: begin
                    word_q     <= {rd_word_d[23:0], 8'h00};
                    tx_data_q  <= rd_word_d[31:24];
                    tx_start_q <= 1'b1;
                    state_q    <= S_DUMP_WAIT;
                end
                S_DUMP_WAIT: begin
                    if (i_tx_done && !tx_start_q) begin
                        if (dump_cnt_q == LAST_BYTE) begin
                            dump_cnt_q <= 16'd0;
                            state_q    <= S_IDLE;
                        end else begin
                            dump_cnt_q <= next_byte_d;
                            if (next_byte_d < WORD_BYTES) begin
                                if (next_byte_d[1:0] == 2'b00) begin
                                    if (fetch_reg_d) raddr_reg_q <= reg_addr_d;
                                    else             raddr_mem_q <= mem_addr_d;
                                    state_q <= S_DUMP_FETCH;
                                end else begin
                                    tx_data_q  <= word_q[31:24];
                                    word_q     <= {word_q[23:0], 8'h00};
                                    tx_start_q <= 1'b1;
                                end
                            end else begin
                                tx_data_q  <= snap_q[SNAP_W-1 -: 8];
                                snap_q     <= {snap_q[SNAP_W-9:0], 8'h00};
                                tx_start_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    halt_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_halt                  = halt_q;
    assign o_tx_start              = tx_start_q;
    assign o_tx_data               = tx_data_q;
    assign o_write_instruction_mem = we_q;
    assign o_instruction_mem_addr  = im_addr_q;
    assign o_instruction_mem_data  = im_data_q;
    assign o_r_addr_registers      = raddr_reg_q;
    assign o_r_addr_data_mem       = raddr_mem_q;
endmodule

// File: tb/tb_debug_unit.sv
// Directed bench for debug_unit: byte-stream and write-strobe expectations come from a bench-side model
// of registers, data memory and stage latches; a negedge process compares and acts as the UART transmitter.
module tb_debug_unit;
    logic         clk = 1'b0;
    logic         i_reset = 1'b1;
    logic [7:0]   i_rx_data = 8'd0;
    logic         i_rx_valid = 1'b0;
    logic [7:0]   o_tx_data;
    logic         o_tx_start;
    logic         i_tx_done = 1'b0;
    logic         i_end = 1'b0;
    logic         o_halt;
    logic         o_write_instruction_mem;
    logic [31:0]  o_instruction_mem_addr, o_instruction_mem_data;
    logic [4:0]   o_r_addr_registers, o_r_addr_data_mem;
    logic [31:0]  i_r_data_registers = 32'd0, i_r_data_data_mem = 32'd0;
    logic [63:0]  i_IF_ID;
    logic [138:0] i_ID_EX;
    logic [75:0]  i_EX_MEM;
    logic [70:0]  i_MEM_WB;

    always #5 clk = ~clk;

    debug_unit dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
        .i_end(i_end), .o_halt(o_halt),
        .o_write_instruction_mem(o_write_instruction_mem),
        .o_instruction_mem_addr(o_instruction_mem_addr),
        .o_instruction_mem_data(o_instruction_mem_data),
        .o_r_addr_registers(o_r_addr_registers), .i_r_data_registers(i_r_data_registers),
        .o_r_addr_data_mem(o_r_addr_data_mem), .i_r_data_data_mem(i_r_data_data_mem),
        .i_IF_ID(i_IF_ID), .i_ID_EX(i_ID_EX), .i_EX_MEM(i_EX_MEM), .i_MEM_WB(i_MEM_WB)
    );

    logic [31:0] reg_m [32];
    logic [31:0] mem_m [32];
    logic [7:0]  exp_q [$];
    logic [63:0] wr_q  [$];
    logic [63:0] wr_e;
    logic [7:0]  got [0:511];
    logic [31:0] last_wr_data = 32'd0;
    int ntx = 0, outstanding = 0, tx_cnt = 0, low_cnt = 0;
    int n_pass = 0, n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Expected dump: every word MSB first, then each latch as ceil(width/8) bytes MSB first.
    task automatic push_latch(input logic [143:0] v, input int nbytes);
        for (int k = 0; k < nbytes; k++) exp_q.push_back(8'(v >> (8 * (nbytes - 1 - k))));
    endtask

    task automatic build_expected();
        exp_q.delete();
        ntx = 0;
        for (int w = 0; w < 32; w++)
            for (int k = 0; k < 4; k++) exp_q.push_back(8'(reg_m[w] >> (24 - 8 * k)));
        for (int w = 0; w < 32; w++)
            for (int k = 0; k < 4; k++) exp_q.push_back(8'(mem_m[w] >> (24 - 8 * k)));
        push_latch(144'(i_IF_ID), (64 + 7) / 8);
        push_latch(144'(i_ID_EX), (139 + 7) / 8);
        push_latch(144'(i_EX_MEM), (76 + 7) / 8);
        push_latch(144'(i_MEM_WB), (71 + 7) / 8);
    endtask

    // Compare process plus transmitter and memory-read responders.
    always @(negedge clk) begin
        if (!i_reset) begin
            if (!o_halt) low_cnt++;
            if (o_write_instruction_mem) begin
                last_wr_data = o_instruction_mem_data;
                if (wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
                else begin
                    wr_e = wr_q.pop_front();
                    check("wr_addr", o_instruction_mem_addr, wr_e[63:32]);
                    check("wr_data", o_instruction_mem_data, wr_e[31:0]);
                end
            end
            if (o_tx_start) begin
                check("tx_overlap", 32'(outstanding), 32'd0);
                if (exp_q.size() == 0) check("tx_extra", 32'd1, 32'd0);
                else check("tx_byte", {24'd0, o_tx_data}, {24'd0, exp_q.pop_front()});
                if (ntx < 512) got[ntx] = o_tx_data;
                ntx++;
            end
        end
        if (i_tx_done) i_tx_done = 1'b0;
        if (o_tx_start) begin
            tx_cnt = 10;
            outstanding = 1;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                i_tx_done = 1'b1;
                outstanding = 0;
            end
        end
        i_r_data_registers = reg_m[o_r_addr_registers];
        i_r_data_data_mem  = mem_m[o_r_addr_data_mem];
    end

    task automatic rx(input logic [7:0] b);
        @(negedge clk);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic rx_burst(input logic [7:0] bs [$]);
        foreach (bs[i]) begin
            @(negedge clk);
            i_rx_data  = bs[i];
            i_rx_valid = 1'b1;
        end
        @(negedge clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic wait_dump();
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && outstanding == 0 && tx_cnt == 0) break;
        end
        check("dump_remaining", 32'(exp_q.size()), 32'd0);
        repeat (40) @(negedge clk);
        check("dump_count", 32'(ntx), 32'd301);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            reg_m[i] = 32'(i) * 32'h1F0E_0D01;
            mem_m[i] = 32'hC000_0000 | (32'(i) * 32'd7);
        end
        i_IF_ID  = 64'h0123_4567_89AB_CDEF;
        i_ID_EX  = {11'h5A5, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
        i_EX_MEM = {12'hABC, 64'h1122_3344_5566_7788};
        i_MEM_WB = {7'h55, 64'h99AA_BBCC_DDEE_FF00};

        repeat (3) @(negedge clk);
        check("rst_halt", {31'd0, o_halt}, 32'd1);
        check("rst_tx_start", {31'd0, o_tx_start}, 32'd0);
        check("rst_tx_data", {24'd0, o_tx_data}, 32'd0);
        check("rst_we", {31'd0, o_write_instruction_mem}, 32'd0);
        check("rst_im_addr", o_instruction_mem_addr, 32'd0);
        check("rst_im_data", o_instruction_mem_data, 32'd0);
        check("rst_raddr", {22'd0, o_r_addr_registers, o_r_addr_data_mem}, 32'd0);
        i_reset = 1'b0;

        // Reset in the middle of a word, then a clean one-word load.
        rx(8'h4C); rx(8'h01); rx(8'h20); rx(8'h01);
        @(negedge clk); i_reset = 1'b1;
        @(negedge clk);
        check("midload_rst_halt", {31'd0, o_halt}, 32'd1);
        check("midload_rst_we", {31'd0, o_write_instruction_mem}, 32'd0);
        i_reset = 1'b0;
        wr_q.push_back({32'h0, 32'h2001_0005});
        rx(8'h4C); rx(8'h01); rx(8'h20); rx(8'h01); rx(8'h00); rx(8'h05);
        repeat (5) @(negedge clk);
        check("load1_pending", 32'(wr_q.size()), 32'd0);
        check("load1_literal", last_wr_data, 32'h2001_0005);

        // Two words sent back to back with no idle cycles.
        begin
            logic [7:0] bs [$];
            bs = '{8'h4C, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
            wr_q.push_back({32'h0, (32'(bs[2]) << 24) | (32'(bs[3]) << 16) | (32'(bs[4]) << 8) | 32'(bs[5])});
            wr_q.push_back({32'h4, (32'(bs[6]) << 24) | (32'(bs[7]) << 16) | (32'(bs[8]) << 8) | 32'(bs[9])});
            rx_burst(bs);
        end
        repeat (5) @(negedge clk);
        check("load2_pending", 32'(wr_q.size()), 32'd0);
        check("load2_literal", last_wr_data, 32'hAABB_CCDD);

        // Zero-length load, then a single step.
        rx(8'h4C); rx(8'h00);
        repeat (3) @(negedge clk);
        build_expected();
        low_cnt = 0;
        rx(8'h53);
        wait_dump();
        check("step_halt_low", 32'(low_cnt), 32'd1);

        // Continuous run, end raised while the 20th unhalted cycle is sampled.
        build_expected();
        low_cnt = 0;
        rx(8'h43);
        repeat (19) @(negedge clk);
        i_end = 1'b1;
        repeat (3) @(negedge clk);
        i_end = 1'b0;
        wait_dump();
        check("run_halt_low", 32'(low_cnt), 32'd20);
        for (int k = 0; k < 4; k++) check("run_reg0_byte", {24'd0, got[k]}, 32'd0);
        check("run_reg1_b0", {24'd0, got[4]}, 32'h1F);
        check("run_reg1_b1", {24'd0, got[5]}, 32'h0E);
        check("run_reg1_b2", {24'd0, got[6]}, 32'h0D);
        check("run_reg1_b3", {24'd0, got[7]}, 32'h01);

        // All-ones ID/EX snapshot, stray command bytes during the dump.
        i_ID_EX = '1;
        build_expected();
        low_cnt = 0;
        rx(8'h53);
        repeat (50) @(negedge clk);
        rx(8'h58);
        rx(8'h43);
        wait_dump();
        check("idex_halt_low", 32'(low_cnt), 32'd1);
        check("idex_pad_byte", {24'd0, got[264]}, 32'h07);
        for (int k = 265; k < 282; k++) check("idex_ones_byte", {24'd0, got[k]}, 32'hFF);
        check("ifid_last_byte", {24'd0, got[263]}, 32'hEF);

        // Back in IDLE: a further load is accepted.
        wr_q.push_back({32'h0, 32'hDEAD_BEEF});
        rx(8'h4C); rx(8'h01); rx(8'hDE); rx(8'hAD); rx(8'hBE); rx(8'hEF);
        repeat (5) @(negedge clk);
        check("post_dump_load", 32'(wr_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
